// File: rtl/axis2bram_interface.sv
// -----------------------------------------------------------------------------
// axis2bram_interface
//
// Receives one AXI4-Stream packet per CTRL_ALLOW grant. Each beat is written
// to BRAM at a byte address that steps by one word per beat. When the packet
// ends, the received byte count is pushed into the depth FIFO, and
// CTRL_FINISHED pulses for one cycle.
//
// Ports
//   ACC_CLK           clock; all logic runs on its rising edge
//   ARESET            synchronous, active-high reset
//   CTRL_ALLOW        permission to receive; must be high for two consecutive
//                     cycles to start a packet
//   CTRL_FINISHED     one-cycle pulse after the depth has been pushed
//   AXIS_TDATA/TVALID/TLAST/TREADY  stream slave (low BRAM_DATA_WIDTH bits stored)
//   BRAM_ADDR/DOUT/EN/WE            registered BRAM write port
//   DATA_DEPTH        byte count presented with DATA_DEPTH_WRITE
//   DATA_DEPTH_WRITE  depth FIFO push strobe
//   DATA_DEPTH_FULL   depth FIFO full; holds the push off
//
// Handshake: a stream beat transfers in every cycle where AXIS_TVALID and
// AXIS_TREADY are both high. The depth FIFO takes a word in every cycle where
// DATA_DEPTH_WRITE is high. DATA_DEPTH_WRITE is never asserted while
// DATA_DEPTH_FULL is high.
// -----------------------------------------------------------------------------
module axis2bram_interface #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int BRAM_ADDR_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_DATA_DEPTH = 4
) (
    input  logic                         ACC_CLK,
    input  logic                         ARESET,
    input  logic                         CTRL_ALLOW,
    output logic                         CTRL_FINISHED,
    input  logic [AXIS_DATA_WIDTH-1:0]   AXIS_TDATA,
    input  logic                         AXIS_TVALID,
    input  logic                         AXIS_TLAST,
    output logic                         AXIS_TREADY,
    output logic [BRAM_ADDR_WIDTH-1:0]   BRAM_ADDR,
    output logic [BRAM_DATA_WIDTH-1:0]   BRAM_DOUT,
    output logic                         BRAM_EN,
    output logic [BRAM_DATA_WIDTH/8-1:0] BRAM_WE,
    output logic [31:0]                  DATA_DEPTH,
    output logic                         DATA_DEPTH_WRITE,
    input  logic                         DATA_DEPTH_FULL
);

    localparam int NUM_BYTES   = BRAM_DATA_WIDTH / 8;
    localparam int DEPTH_BYTES = BRAM_DATA_DEPTH * NUM_BYTES;

    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_STEP  = BRAM_ADDR_WIDTH'(NUM_BYTES);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_LIMIT = BRAM_ADDR_WIDTH'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DEPTH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic                         allow_reg;
    logic [BRAM_ADDR_WIDTH-1:0]   wr_addr;
    logic                         handshake;
    logic                         space_left;

    assign handshake  = AXIS_TVALID && AXIS_TREADY;
    // Once the BRAM is full, wr_addr stops at ADDR_LIMIT. It therefore doubles
    // as the saturated byte count.
    assign space_left = (wr_addr < ADDR_LIMIT);

    // The depth is only presented while the push is pending, so the FIFO
    // never sees an intermediate count.
    assign DATA_DEPTH = (state == S_DEPTH) ? 32'(wr_addr) : 32'd0;

    always_comb begin
        state_next       = state;
        AXIS_TREADY      = 1'b0;
        DATA_DEPTH_WRITE = 1'b0;
        CTRL_FINISHED    = 1'b0;
        case (state)
            S_IDLE: begin
                // The grant must be seen on two consecutive cycles, so a
                // one-cycle glitch on CTRL_ALLOW cannot start a transfer.
                if (allow_reg && CTRL_ALLOW) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                AXIS_TREADY = 1'b1;
                if (handshake && AXIS_TLAST) begin
                    state_next = S_DEPTH;
                end
            end
            S_DEPTH: begin
                DATA_DEPTH_WRITE = !DATA_DEPTH_FULL;
                if (!DATA_DEPTH_FULL) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                CTRL_FINISHED = 1'b1;
                state_next    = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACC_CLK) begin
        if (ARESET) begin
            state     <= S_IDLE;
            allow_reg <= 1'b0;
            wr_addr   <= '0;
            BRAM_EN   <= 1'b0;
            BRAM_WE   <= '0;
            BRAM_ADDR <= '0;
            BRAM_DOUT <= '0;
        end else begin
            state     <= state_next;
            allow_reg <= CTRL_ALLOW;
            BRAM_EN   <= 1'b0;
            BRAM_WE   <= '0;
            // Beats arriving after the BRAM is full are accepted but dropped.
            if (handshake && space_left) begin
                BRAM_EN   <= 1'b1;
                BRAM_WE   <= '1;
                BRAM_ADDR <= wr_addr;
                BRAM_DOUT <= AXIS_TDATA[BRAM_DATA_WIDTH-1:0];
                wr_addr   <= wr_addr + ADDR_STEP;
            end
            if (state == S_IDLE || state == S_DONE) begin
                wr_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis2bram_interface.sv
// -----------------------------------------------------------------------------
// tb_axis2bram_interface
//
// Drives packets into axis2bram_interface. For each packet, the reference
// model works out the writes the BRAM must see and the byte count the depth
// FIFO must receive:
//   - the first BRAM_DATA_DEPTH beats are written, at word index * NUM_BYTES;
//   - the pushed depth is min(beats, BRAM_DATA_DEPTH) * NUM_BYTES.
// A monitor on the falling edge pops these expectations as the DUT produces
// writes, depth pushes and finish pulses.
// -----------------------------------------------------------------------------
module tb_axis2bram_interface;

    localparam int AW  = 64;
    localparam int BA  = 32;
    localparam int BD  = 32;
    localparam int DEP = 4;
    localparam int NB  = BD / 8;

    logic          ACC_CLK;
    logic          ARESET;
    logic          CTRL_ALLOW;
    logic          CTRL_FINISHED;
    logic [AW-1:0] AXIS_TDATA;
    logic          AXIS_TVALID;
    logic          AXIS_TLAST;
    logic          AXIS_TREADY;
    logic [BA-1:0] BRAM_ADDR;
    logic [BD-1:0] BRAM_DOUT;
    logic          BRAM_EN;
    logic [NB-1:0] BRAM_WE;
    logic [31:0]   DATA_DEPTH;
    logic          DATA_DEPTH_WRITE;
    logic          DATA_DEPTH_FULL;

    axis2bram_interface #(
        .AXIS_DATA_WIDTH(AW),
        .BRAM_ADDR_WIDTH(BA),
        .BRAM_DATA_WIDTH(BD),
        .BRAM_DATA_DEPTH(DEP)
    ) dut (
        .ACC_CLK         (ACC_CLK),
        .ARESET          (ARESET),
        .CTRL_ALLOW      (CTRL_ALLOW),
        .CTRL_FINISHED   (CTRL_FINISHED),
        .AXIS_TDATA      (AXIS_TDATA),
        .AXIS_TVALID     (AXIS_TVALID),
        .AXIS_TLAST      (AXIS_TLAST),
        .AXIS_TREADY     (AXIS_TREADY),
        .BRAM_ADDR       (BRAM_ADDR),
        .BRAM_DOUT       (BRAM_DOUT),
        .BRAM_EN         (BRAM_EN),
        .BRAM_WE         (BRAM_WE),
        .DATA_DEPTH      (DATA_DEPTH),
        .DATA_DEPTH_WRITE(DATA_DEPTH_WRITE),
        .DATA_DEPTH_FULL (DATA_DEPTH_FULL)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial ACC_CLK = 1'b0;
    always #5 ACC_CLK = ~ACC_CLK;

    int cyc = 0;
    always @(posedge ACC_CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [BA-1:0] exp_addr_q[$];
    logic [BD-1:0] exp_data_q[$];
    logic [31:0]   exp_depth_q[$];
    int            exp_push_cyc = -1;
    int            push_cyc     = -100;
    int            fin_count    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge ACC_CLK) begin : monitor
        logic [BA-1:0] ea;
        logic [BD-1:0] ed;
        logic [31:0]   edp;
        if (!ARESET) begin
            if (BRAM_EN) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", BRAM_ADDR, BRAM_DOUT);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    chk("wr_addr", 64'(BRAM_ADDR), 64'(ea));
                    chk("wr_data", 64'(BRAM_DOUT), 64'(ed));
                    chk("wr_we",   64'(BRAM_WE),   64'({NB{1'b1}}));
                end
            end else begin
                chk("we_idle", 64'(BRAM_WE), 64'd0);
            end
            if (DATA_DEPTH_WRITE) begin
                if (exp_depth_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_depth_push: depth %0d, no push expected", DATA_DEPTH);
                end else begin
                    edp = exp_depth_q.pop_front();
                    chk("depth_value", 64'(DATA_DEPTH), 64'(edp));
                    chk("push_cycle",  64'(cyc), 64'(exp_push_cyc));
                end
                push_cyc = cyc;
            end
            if (CTRL_FINISHED) begin
                chk("finish_cycle", 64'(cyc), 64'(push_cyc + 1));
                fin_count++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge ACC_CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"},  64'(AXIS_TREADY),      64'd0);
        chk({tag, "_en"},      64'(BRAM_EN),          64'd0);
        chk({tag, "_we"},      64'(BRAM_WE),          64'd0);
        chk({tag, "_addr"},    64'(BRAM_ADDR),        64'd0);
        chk({tag, "_dout"},    64'(BRAM_DOUT),        64'd0);
        chk({tag, "_depth"},   64'(DATA_DEPTH),       64'd0);
        chk({tag, "_dwrite"},  64'(DATA_DEPTH_WRITE), 64'd0);
        chk({tag, "_finish"},  64'(CTRL_FINISHED),    64'd0);
    endtask

    task automatic do_reset;
        ARESET = 1'b1;
        tick;
        tick;
        ARESET = 1'b0;
        check_reset_outputs("reset");
    endtask

    // The grant is raised in cycle S. The stream must be ready in S+2 and not before.
    task automatic start_pkt;
        CTRL_ALLOW = 1'b1;
        tick;
        chk("tready_early", 64'(AXIS_TREADY), 64'd0);
        tick;
        chk("tready_start", 64'(AXIS_TREADY), 64'd1);
        // Dropping the grant once running must not cut the packet short.
        CTRL_ALLOW = 1'b0;
    endtask

    // Drives one beat and records what the BRAM must receive for it.
    task automatic drive_beat(input int idx, input logic [AW-1:0] d, input bit last);
        AXIS_TDATA  = d;
        AXIS_TVALID = 1'b1;
        AXIS_TLAST  = last;
        chk("tready_run", 64'(AXIS_TREADY), 64'd1);
        if (idx < DEP) begin
            exp_addr_q.push_back(BA'(idx * NB));
            exp_data_q.push_back(d[BD-1:0]);
        end
        tick;
    endtask

    task automatic send_pkt(input int n, input int max_gap, input int full_cycles, input bit fixed);
        int            f0;
        int            tl;
        int            edepth;
        logic [AW-1:0] d;
        f0 = fin_count;
        start_pkt;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                AXIS_TVALID = 1'b0;
                AXIS_TDATA  = {$urandom, $urandom};
                tick;
            end
            d = fixed ? AW'(8'hA0 + i) : {$urandom, $urandom};
            drive_beat(i, d, i == n - 1);
        end
        tl          = cyc - 1;
        AXIS_TVALID = 1'b0;
        AXIS_TLAST  = 1'b0;
        AXIS_TDATA  = {$urandom, $urandom};
        edepth      = ((n < DEP) ? n : DEP) * NB;
        exp_depth_q.push_back(32'(edepth));
        exp_push_cyc = tl + 1 + full_cycles;
        chk("tready_after_last", 64'(AXIS_TREADY), 64'd0);
        if (full_cycles > 0) begin
            DATA_DEPTH_FULL = 1'b1;
            for (int k = 0; k < full_cycles; k++) begin
                #1;
                chk("depth_hold_write", 64'(DATA_DEPTH_WRITE), 64'd0);
                chk("depth_stable",     64'(DATA_DEPTH),       64'(edepth));
                tick;
            end
            DATA_DEPTH_FULL = 1'b0;
        end
        for (int k = 0; k < 20 && fin_count == f0; k++) tick;
        if (fin_count == f0) begin
            checks++;
            errors++;
            $display("FAIL finish_timeout: no CTRL_FINISHED within 20 cycles of packet end");
        end
        tick;
        tick;
        chk("finish_once",   64'(fin_count),          64'(f0 + 1));
        chk("writes_drained", 64'(exp_addr_q.size()), 64'd0);
        chk("depth_drained",  64'(exp_depth_q.size()), 64'd0);
    endtask

    task automatic allow_glitch;
        CTRL_ALLOW  = 1'b1;
        tick;
        CTRL_ALLOW  = 1'b0;
        AXIS_TVALID = 1'b1;
        AXIS_TDATA  = {$urandom, $urandom};
        repeat (5) begin
            chk("glitch_tready", 64'(AXIS_TREADY), 64'd0);
            tick;
        end
        AXIS_TVALID = 1'b0;
    endtask

    task automatic reset_mid_packet;
        start_pkt;
        drive_beat(0, {$urandom, $urandom}, 1'b0);
        drive_beat(1, {$urandom, $urandom}, 1'b0);
        AXIS_TVALID = 1'b0;
        tick;
        ARESET = 1'b1;
        tick;
        ARESET = 1'b0;
        check_reset_outputs("midreset");
        repeat (4) tick;
        chk("midreset_writes", 64'(exp_addr_q.size()), 64'd0);
        send_pkt(4, 0, 0, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        ARESET          = 1'b1;
        CTRL_ALLOW      = 1'b0;
        AXIS_TDATA      = '0;
        AXIS_TVALID     = 1'b0;
        AXIS_TLAST      = 1'b0;
        DATA_DEPTH_FULL = 1'b0;
        do_reset;

        send_pkt(4, 0, 0, 1'b1);   // basic packet, data 0xA0..0xA3
        send_pkt(1, 0, 0, 1'b0);   // single beat
        send_pkt(6, 2, 0, 1'b0);   // overflow with bubbles
        send_pkt(4, 0, 3, 1'b0);   // depth FIFO backpressure
        allow_glitch;
        reset_mid_packet;
        for (int p = 0; p < 8; p++) begin
            send_pkt($urandom_range(1, 7), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis2bram_interface.md
# axis2bram_interface

Receive-side counterpart of the BRAM-to-stream adapter in the accelerator adapter IP. It accepts an AXI4-Stream packet from upstream logic, writes each beat into BRAM at byte-addressed, word-stepped locations, and pushes the received byte count into a depth FIFO. That FIFO is the one the downstream BRAM reader consumes. A two-cycle control handshake (`CTRL_ALLOW` / `CTRL_FINISHED`) frames each packet.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 64: stream data width; must be ≥ `BRAM_DATA_WIDTH`.
- `BRAM_ADDR_WIDTH`, 32: BRAM byte-address width.
- `BRAM_DATA_WIDTH`, 32: BRAM word width, a multiple of 8. `NUM_BYTES` = `BRAM_DATA_WIDTH`/8.
- `BRAM_DATA_DEPTH`, 4: BRAM capacity in words. `DEPTH_BYTES` = `BRAM_DATA_DEPTH`*`NUM_BYTES`.

Ports:
- `ACC_CLK`  in  1  single clock, all logic on rising edge.
- `ARESET`  in  1  reset; synchronous, active-high.
- `CTRL_ALLOW`  in  1  permission to receive a packet.
- `CTRL_FINISHED`  out  1  one-cycle pulse when the packet is stored and its depth is pushed.
- `AXIS_TDATA`  in  `AXIS_DATA_WIDTH`  stream data; only bits [`BRAM_DATA_WIDTH`-1:0] are stored.
- `AXIS_TVALID`  in  1  stream valid.
- `AXIS_TLAST`  in  1  last beat of the packet.
- `AXIS_TREADY`  out  1  stream ready.
- `BRAM_ADDR`  out  `BRAM_ADDR_WIDTH`  write byte address.
- `BRAM_DOUT`  out  `BRAM_DATA_WIDTH`  write data.
- `BRAM_EN`  out  1  BRAM enable.
- `BRAM_WE`  out  `NUM_BYTES`  byte write enables; all ones or all zeros.
- `DATA_DEPTH`  out  32  received byte count.
- `DATA_DEPTH_WRITE`  out  1  depth FIFO push strobe.
- `DATA_DEPTH_FULL`  in  1  depth FIFO full.

## Operation
- `allow_reg` is `CTRL_ALLOW` delayed by one cycle.
- States: IDLE, RUN, DEPTH, DONE.
- **IDLE**
  - `wr_addr` = 0.
  - When `allow_reg` && `CTRL_ALLOW`, go to RUN. A single-cycle `CTRL_ALLOW` pulse never starts a transfer.
- **RUN**
  - `AXIS_TREADY` = 1.
  - On each handshake (`TVALID` && `TREADY`):
    - If `wr_addr` < `DEPTH_BYTES`: register a write of `TDATA`[low] at `wr_addr`, then `wr_addr` += `NUM_BYTES`.
    - Otherwise (overflow): accept the beat, drop it with no write, and leave `wr_addr` unchanged.
  - A handshake with `TLAST` = 1 moves to DEPTH.
  - Deasserting `CTRL_ALLOW` in RUN is ignored; the packet always runs to `TLAST`.
- **DEPTH**
  - `AXIS_TREADY` = 0.
  - `DATA_DEPTH` = `wr_addr`, i.e. written beats × `NUM_BYTES`, saturated at `DEPTH_BYTES`.
  - `DATA_DEPTH_WRITE` = !`DATA_DEPTH_FULL` (combinational decode of state).
  - Leave for DONE in the cycle the push occurs. While `DATA_DEPTH_FULL`, hold DEPTH indefinitely.
- **DONE**
  - Lasts exactly one cycle: `CTRL_FINISHED` = 1, clear `wr_addr`, go to IDLE.
- Address arithmetic is `BRAM_ADDR_WIDTH` unsigned and never wraps, because the address saturates at `DEPTH_BYTES`.
- `ARESET` in any state forces IDLE next cycle. It aborts any pending write and depth push; no partial depth is ever pushed.

## Timing
- Reset values: `AXIS_TREADY` 0, `BRAM_EN` 0, `BRAM_WE` 0, `BRAM_ADDR` 0, `BRAM_DOUT` 0, `DATA_DEPTH` 0, `DATA_DEPTH_WRITE` 0, `CTRL_FINISHED` 0.
- Start sequence: `CTRL_ALLOW` high in cycles S and S+1 → RUN from S+2, with `AXIS_TREADY` high in S+2.
- Writes are registered: a handshake in cycle N drives `BRAM_EN`=1, `WE`=all ones, `ADDR`, and `DOUT` for exactly cycle N+1. Otherwise `EN`/`WE` are 0.
- Throughput is one beat per cycle; gaps in `TVALID` produce gaps in writes.
- `TLAST` handshake in cycle N: last write in N+1; `AXIS_TREADY` = 0 from N+1; DEPTH from N+1.
- With the FIFO not full: `DATA_DEPTH_WRITE` in N+1, `CTRL_FINISHED` in N+2, IDLE in N+3.
- Each full cycle in DEPTH adds one cycle of delay.
- Earliest next start: `CTRL_ALLOW` held high through N+3 → RUN at N+4.

## Test plan
- **Basic packet:** `BRAM_DATA_DEPTH`=4; allow held, 4 back-to-back beats `0xA0..0xA3`, `TLAST` on the 4th. Required response:
  - writes at ADDR 0/4/8/12 with matching `DOUT`, `WE`=4'hF;
  - one `DATA_DEPTH_WRITE` with `DATA_DEPTH`=16;
  - `CTRL_FINISHED` one cycle later.
- **Single beat:** one beat with `TLAST` → one write at ADDR 0, `DATA_DEPTH`=4, `FINISHED` pulse 2 cycles after the handshake.
- **Overflow and bubbles:** 6 beats with `TVALID` gaps, `TLAST` on the 6th. Required response:
  - only 4 writes (ADDR 0..12), beats 5–6 accepted but not written;
  - `DATA_DEPTH`=16;
  - no write in any gap cycle.
- **Depth FIFO backpressure:** `DATA_DEPTH_FULL` high for 3 cycles after `TLAST` → push delayed exactly 3 cycles; `DATA_DEPTH` stable throughout; `FINISHED` follows the push by 1 cycle.
- **Allow glitch:** 1-cycle `CTRL_ALLOW` pulse → `TREADY` stays 0; no writes.
- **Reset mid-packet:** `ARESET` after 2 beats → all outputs at reset values next cycle; no depth push. A following full 4-beat packet restarts at ADDR 0 with `DATA_DEPTH`=16.
